difficulty_selector: RTL and testbench
======================================

DIFFICULTY_SELECTOR -- requirements
Module: difficulty_selector

Interface
REQ-001 Parameter EASY_CODE, default 4'b0001, difficulty code driven when Easy is selected.
REQ-002 Parameter MEDIUM_CODE, default 4'b0010, difficulty code driven when Medium is selected.
REQ-003 Parameter HARD_CODE, default 4'b0100, difficulty code driven when Hard is selected.
REQ-004 clk  input  1  single system clock; all state SHALL update on its rising edge only.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 KEY0_debounced  input  1  Hard request; active-high, already debounced, level-sensitive.
REQ-007 KEY1_debounced  input  1  Medium request; active-high, already debounced, level-sensitive.
REQ-008 KEY2_debounced  input  1  Easy request; active-high, already debounced, level-sensitive.
REQ-009 difficulty  output  4  registered current difficulty code; always exactly one of EASY_CODE, MEDIUM_CODE or HARD_CODE; bit 3 always 0 with default codes.
REQ-010 difficulty_changed  output  1  registered one-cycle pulse, high in the cycle after difficulty takes a new, different value.

Function
REQ-011 Each rising edge of clk, the block SHALL sample the three keys and resolve them by fixed priority: Hard (KEY0) > Medium (KEY1) > Easy (KEY2).
REQ-012 If exactly one key is high, difficulty SHALL take that key's code on the next rising edge (latency 1 cycle).
REQ-013 If several keys are high simultaneously, the highest-priority key SHALL win (all three high -> HARD_CODE; KEY1+KEY2 -> MEDIUM_CODE; KEY0+KEY2 -> HARD_CODE).
REQ-014 If no key is high, difficulty SHALL hold its previous value indefinitely (selection is latched, not momentary).
REQ-015 A key held high for many cycles SHALL keep difficulty at that code and SHALL NOT generate repeated difficulty_changed pulses.
REQ-016 difficulty_changed SHALL be 1 for exactly one cycle, coincident with the first cycle difficulty shows a new value, and SHALL be 0 when a request repeats the current code.
REQ-017 Unknown or illegal internal state SHALL recover to EASY_CODE on the next edge; difficulty SHALL never show a code other than the three legal codes.
REQ-018 Outputs SHALL be driven directly from flip-flops; no combinational path from keys to outputs.

Reset
REQ-019 While reset is high at a rising edge, difficulty SHALL become EASY_CODE and difficulty_changed SHALL become 0, regardless of key inputs.
REQ-020 Reset SHALL take priority over key requests in the same cycle; the first cycle after reset deasserts resolves keys normally (latency 1 cycle).
REQ-021 Reset asserted mid-operation (e.g. while Hard is selected and KEY0 held) SHALL force EASY_CODE; after release with KEY0 still high, difficulty SHALL return to HARD_CODE one cycle later with a difficulty_changed pulse.
REQ-022 A return to EASY_CODE caused by reset SHALL NOT pulse difficulty_changed.

Structure
REQ-023 The three default difficulty codes and a 2-bit level enumeration (EASY, MEDIUM, HARD) SHALL live in a shared package (difficulty_pkg) so game logic consumers decode difficulty identically.
REQ-024 A combinational sub-module, difficulty_priority_encoder (three keys in -> valid flag plus 2-bit level out), is the natural split; the state register, code mapping and change-pulse logic stay in difficulty_selector.

Verification
REQ-025 Reset asserted 2 cycles, keys 0 -> difficulty = 0001, difficulty_changed = 0.
REQ-026 Sequence KEY2 only, KEY1 only, KEY0 only, 10 cycles each -> difficulty 0001, 0010, 0100, each one cycle after the key rises; one difficulty_changed pulse at Medium and at Hard, none at Easy (already Easy).
REQ-027 After Hard selected, all keys 0 for 20 cycles -> difficulty stays 0100, difficulty_changed stays 0.
REQ-028 All three keys high from Easy -> difficulty 0100 after 1 cycle; KEY1+KEY2 high next -> 0010; single pulse per change.
REQ-029 Hard selected, KEY0 held, reset pulsed 1 cycle -> difficulty 0001 during reset cycle, 0100 one cycle after release, one difficulty_changed pulse.
REQ-030 Repeat the five-case pattern (Easy, Medium, Hard, none, all) 5 times with 10 cycles per case -> difficulty per case 0001, 0010, 0100, 0100 (held), 0100; checker asserts legality of difficulty every cycle.

Source files
------------

// File: rtl/difficulty_pkg.sv
// Shared difficulty encodings so every consumer of the selector decodes the
// difficulty bus the same way.
package difficulty_pkg;

   localparam logic [3:0] DEFAULT_EASY_CODE   = 4'b0001;
   localparam logic [3:0] DEFAULT_MEDIUM_CODE = 4'b0010;
   localparam logic [3:0] DEFAULT_HARD_CODE   = 4'b0100;

   typedef enum logic [1:0] {
      LVL_EASY   = 2'd0,
      LVL_MEDIUM = 2'd1,
      LVL_HARD   = 2'd2
   } level_e;

   function automatic logic level_is_legal(input level_e lvl);
      return (lvl == LVL_EASY) || (lvl == LVL_MEDIUM) || (lvl == LVL_HARD);
   endfunction

endpackage

// File: rtl/difficulty_selector_if.sv
// Key request inputs and difficulty outputs of the difficulty selector.
interface difficulty_selector_if;
   logic       KEY0_debounced;
   logic       KEY1_debounced;
   logic       KEY2_debounced;
   logic [3:0] difficulty;
   logic       difficulty_changed;

   modport master (
      output KEY0_debounced, KEY1_debounced, KEY2_debounced,
      input  difficulty, difficulty_changed
   );

   modport slave (
      input  KEY0_debounced, KEY1_debounced, KEY2_debounced,
      output difficulty, difficulty_changed
   );
endinterface

// File: rtl/difficulty_priority_encoder.sv
// Fixed-priority resolution of the three difficulty keys: Hard > Medium > Easy.
module difficulty_priority_encoder
   import difficulty_pkg::*;
(
   input  logic   key_hard,
   input  logic   key_medium,
   input  logic   key_easy,
   output logic   valid,
   output level_e level
);

   always_comb begin
      valid = key_hard | key_medium | key_easy;
      level = LVL_EASY;
      if (key_hard)
         level = LVL_HARD;
      else if (key_medium)
         level = LVL_MEDIUM;
   end

endmodule

// File: rtl/difficulty_selector.sv
// Latched difficulty selection from debounced keys, with a one-cycle change pulse.
//
//  state       | meaning
//  ------------+-----------------------------------------------
//  LVL_EASY    | Easy selected (reset value), drives EASY_CODE
//  LVL_MEDIUM  | Medium selected, drives MEDIUM_CODE
//  LVL_HARD    | Hard selected, drives HARD_CODE
//  (other)     | illegal, recovers to LVL_EASY on the next edge
module difficulty_selector
   import difficulty_pkg::*;
#(
   parameter logic [3:0] EASY_CODE   = DEFAULT_EASY_CODE,
   parameter logic [3:0] MEDIUM_CODE = DEFAULT_MEDIUM_CODE,
   parameter logic [3:0] HARD_CODE   = DEFAULT_HARD_CODE
)(
   input  logic                  clk,
   input  logic                  reset,
   difficulty_selector_if.slave  bus
);

   level_e     level;
   level_e     req_level;
   logic       req_valid;
   logic [3:0] difficulty_q;
   logic       changed_q;

   function automatic logic [3:0] code_of(input level_e lvl);
      case (lvl)
         LVL_MEDIUM: return MEDIUM_CODE;
         LVL_HARD:   return HARD_CODE;
         default:    return EASY_CODE;
      endcase
   endfunction

   difficulty_priority_encoder u_prio (
      .key_hard   (bus.KEY0_debounced),
      .key_medium (bus.KEY1_debounced),
      .key_easy   (bus.KEY2_debounced),
      .valid      (req_valid),
      .level      (req_level)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         level        <= LVL_EASY;
         difficulty_q <= EASY_CODE;
         changed_q    <= 1'b0;
      end else if (req_valid) begin
         level        <= req_level;
         difficulty_q <= code_of(req_level);
         changed_q    <= (req_level != level);
      end else begin
         // No request: hold, but re-derive the code so a corrupted register self-heals.
         level        <= level_is_legal(level) ? level : LVL_EASY;
         difficulty_q <= code_of(level);
         changed_q    <= 1'b0;
      end
   end

   assign bus.difficulty         = difficulty_q;
   assign bus.difficulty_changed = changed_q;

endmodule

// File: tb/tb_difficulty_selector.sv
// Scoreboard bench for difficulty_selector: directed scenarios plus random key traffic.
module tb_difficulty_selector;

   localparam logic [3:0] C_EASY   = 4'b0001;
   localparam logic [3:0] C_MEDIUM = 4'b0010;
   localparam logic [3:0] C_HARD   = 4'b0100;

   typedef struct packed {
      logic [3:0] diff;
      logic       chg;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   difficulty_selector_if bus ();

   difficulty_selector dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   exp_t       exp_q[$];
   int         checks   = 0;
   int         failures = 0;
   logic [3:0] m_diff   = C_EASY;
   bit         started  = 0;

   initial begin
      bus.KEY0_debounced = 1'b0;
      bus.KEY1_debounced = 1'b0;
      bus.KEY2_debounced = 1'b0;
   end

   // Reference: latched selection, priority Hard > Medium > Easy, pulse only on a
   // key-driven change of value, reset forces Easy silently.
   task automatic step(input logic k0, input logic k1, input logic k2, input logic rst);
      exp_t       e;
      logic [3:0] nxt;
      @(negedge clk);
      reset              = rst;
      bus.KEY0_debounced = k0;
      bus.KEY1_debounced = k1;
      bus.KEY2_debounced = k2;
      if (rst)     nxt = C_EASY;
      else if (k0) nxt = C_HARD;
      else if (k1) nxt = C_MEDIUM;
      else if (k2) nxt = C_EASY;
      else         nxt = m_diff;
      e.diff = nxt;
      e.chg  = !rst && (k0 || k1 || k2) && (nxt != m_diff);
      m_diff = nxt;
      exp_q.push_back(e);
      started = 1;
   endtask

   task automatic hold(input logic k0, input logic k1, input logic k2, input logic rst,
                       input int n);
      for (int i = 0; i < n; i++) step(k0, k1, k2, rst);
   endtask

   task automatic check4(input string name, input logic [3:0] act, input logic [3:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
      end
   endtask

   always @(posedge clk) begin
      exp_t e;
      #2;
      if (started) begin
         checks++;
         if (!(bus.difficulty inside {C_EASY, C_MEDIUM, C_HARD})) begin
            failures++;
            $display("FAIL legal_code: got %b expected one of 0001/0010/0100 at %0t",
                     bus.difficulty, $time);
         end
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check4("difficulty", bus.difficulty, e.diff);
         check1("difficulty_changed", bus.difficulty_changed, e.chg);
      end
   end

   initial begin
      // reset two cycles, keys low
      hold(0, 0, 0, 1, 2);
      // Easy, Medium, Hard, 10 cycles each
      hold(0, 0, 1, 0, 10);
      hold(0, 1, 0, 0, 10);
      hold(1, 0, 0, 0, 10);
      // idle keeps Hard
      hold(0, 0, 0, 0, 20);
      // back to Easy, then all keys, then KEY1+KEY2
      hold(0, 0, 1, 0, 3);
      hold(1, 1, 1, 0, 5);
      hold(0, 1, 1, 0, 5);
      hold(1, 0, 1, 0, 5);
      // mid-operation reset with KEY0 held
      hold(1, 0, 0, 0, 4);
      hold(1, 0, 0, 1, 1);
      hold(1, 0, 0, 0, 5);
      // five-case pattern repeated
      for (int r = 0; r < 5; r++) begin
         hold(0, 0, 1, 0, 10);
         hold(0, 1, 0, 0, 10);
         hold(1, 0, 0, 0, 10);
         hold(0, 0, 0, 0, 10);
         hold(1, 1, 1, 0, 10);
      end
      // random traffic with occasional reset
      for (int i = 0; i < 400; i++) begin
         logic [2:0] k;
         k = 3'($urandom_range(0, 7));
         step(k[0], k[1], k[2], ($urandom_range(0, 19) == 0));
      end
      step(0, 0, 0, 0);
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
